// File: rtl/fc_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : fc_neuron_mac
// Purpose  : Sequential multiply-accumulate for one fully-connected neuron.
//            Streams N_INPUTS signed activation/weight pairs over a
//            valid/ready handshake, adds a bias, then rounds (half toward
//            +infinity) and saturates the sum to a signed DATA_W result with
//            FRAC_BITS fractional bits. The result is presented as oa to the
//            ReLU stage downstream; oa itself is not clipped at zero.
//
// Ports    : clk       - system clock, rising edge
//            rst       - synchronous active-high reset
//            start     - begin an evaluation (honoured only in IDLE)
//            bias      - signed bias, sampled when start is honoured
//            in_valid  - x/w beat valid
//            in_ready  - beat accepted this cycle if in_valid (ACC only)
//            x, w      - signed activation / weight
//            oa_valid  - oa holds a finished result
//            oa_ready  - downstream accepts oa
//            oa        - rounded, saturated neuron sum (pre-activation)
//            busy      - high in every state except IDLE
//
// Revision : 1.0 - initial release
// ============================================================================
module fc_neuron_mac #(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int N_INPUTS  = 64,
  parameter int ACC_W     = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic                     oa_valid,
  input  logic                     oa_ready,
  output logic signed [DATA_W-1:0] oa,
  output logic                     busy
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int PROD_W = 2 * DATA_W;
  // One extra bit so adding the rounding constant can never overflow.
  localparam int RND_W  = ACC_W + 1;
  localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

  localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    DRAIN = 3'd2,
    SAT   = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t                    state;
  logic        [CNT_W-1:0]   count;
  logic signed [PROD_W-1:0]  prod;
  logic                      prod_valid;
  logic signed [ACC_W-1:0]   acc;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic                      accept;
  logic signed [PROD_W-1:0]  mul;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [RND_W-1:0]   acc_wide;
  logic signed [RND_W-1:0]   acc_shr;
  logic [RND_W-DATA_W:0]     shr_hi;
  logic signed [DATA_W-1:0]  sat_val;

  assign accept = in_valid && in_ready;

  // Full-width signed product: both operands sign-extended to PROD_W first.
  assign mul = $signed({{DATA_W{x[DATA_W-1]}}, x}) *
               $signed({{DATA_W{w[DATA_W-1]}}, w});

  // Bias is aligned to the product scale (2*FRAC_BITS fractional bits).
  assign bias_ext = $signed({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias}) <<< FRAC_BITS;
  assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
  assign acc_wide = $signed({acc[ACC_W-1], acc});

  // Round half toward +infinity then arithmetic shift back to FRAC_BITS
  // fractional bits.
  generate
    if (FRAC_BITS > 0) begin : g_round
      localparam logic signed [RND_W-1:0] HALF_LSB = RND_W'(1) << (FRAC_BITS - 1);
      logic signed [RND_W-1:0] acc_rnd;
      assign acc_rnd = acc_wide + HALF_LSB;
      assign acc_shr = acc_rnd >>> FRAC_BITS;
    end else begin : g_no_round
      assign acc_shr = acc_wide;
    end
  endgenerate

  // The value fits in DATA_W exactly when every bit from the result's sign
  // position upward matches; otherwise clamp toward the true sign.
  assign shr_hi  = acc_shr[RND_W-1:DATA_W-1];
  assign sat_val = ((&shr_hi) || !(|shr_hi)) ? acc_shr[DATA_W-1:0]
                 : (acc_shr[RND_W-1] ? SAT_MIN : SAT_MAX);

  // Handshake/status outputs are pure decodes of the state register.
  assign in_ready = (state == ACC);
  assign busy     = (state != IDLE);

  // --------------------------------------------------------------------------
  // Sequential logic: FSM, two-stage MAC pipeline and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      oa         <= '0;
      oa_valid   <= 1'b0;
    end else begin
      // Stage 1: register the product of an accepted beat.
      prod_valid <= accept;
      if (accept) begin
        prod <= mul;
      end

      // Stage 2: fold the registered product in. This also runs in DRAIN
      // for the final beat. The IDLE branch below overrides it on start,
      // but prod_valid is always clear by the time the FSM reaches IDLE.
      if (prod_valid) begin
        acc <= acc + prod_ext;
      end

      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias_ext;
            count <= '0;
            state <= ACC;
          end
        end

        ACC: begin
          if (accept) begin
            count <= count + CNT_W'(1);
            if (count == LAST_BEAT) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          state <= SAT;
        end

        SAT: begin
          oa       <= sat_val;
          oa_valid <= 1'b1;
          state    <= OUT;
        end

        OUT: begin
          // oa keeps its value after the transfer; only the valid drops.
          if (oa_ready) begin
            oa_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
